// File: rtl/sa_psum_drain.sv
// sa_psum_drain: re-aligns skewed psum columns through per-lane FIFOs and streams whole rows per tile.
// Optional PSUM_RELU_EN applies a signed ReLU to each lane of row_data_o.
module sa_psum_drain #(
    parameter int PE_SIZE    = 4,
    parameter int PSUM_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int ROW_CNT_W  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [PSUM_WIDTH*PE_SIZE-1:0] psum_row_i,
    input  logic [PE_SIZE-1:0]            psum_en_i,
    input  logic                          start_i,
    input  logic [ROW_CNT_W-1:0]          num_rows_i,
    input  logic                          clear_i,
    output logic [PSUM_WIDTH*PE_SIZE-1:0] row_data_o,
    output logic                          row_valid_o,
    input  logic                          row_ready_i,
    output logic [ROW_CNT_W-1:0]          row_idx_o,
    output logic                          tile_done_o,
    output logic                          busy_o,
    output logic                          overflow_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t               state, state_nx;
    logic [PE_SIZE-1:0]   empty, full, push;
    logic [ROW_CNT_W-1:0] row_cnt, num_rows;
    logic                 pop, last;

    assign pop       = row_valid_o && row_ready_i;
    assign last      = row_cnt == num_rows - 1'b1;
    assign row_idx_o = row_cnt;

    for (genvar g = 0; g < PE_SIZE; g++) begin : g_lane
        logic [PSUM_WIDTH-1:0] mem [FIFO_DEPTH];
        logic [AW:0]           wr_ptr, rd_ptr;
        logic [PSUM_WIDTH-1:0] head;
        assign empty[g] = wr_ptr == rd_ptr;
        assign full[g]  = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
        // a full lane still accepts when the row pops in the same cycle
        assign push[g]  = psum_en_i[g] && (!full[g] || pop);
        assign head     = mem[rd_ptr[AW-1:0]];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else if (clear_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push[g]) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
            end
        end
        always_ff @(posedge clk) begin
            if (push[g] && !clear_i) mem[wr_ptr[AW-1:0]] <= psum_row_i[PSUM_WIDTH*(PE_SIZE-g)-1 -: PSUM_WIDTH];
        end
`ifdef PSUM_RELU_EN
        assign row_data_o[PSUM_WIDTH*(PE_SIZE-g)-1 -: PSUM_WIDTH] = (row_valid_o && !head[PSUM_WIDTH-1]) ? head : '0;
`else
        assign row_data_o[PSUM_WIDTH*(PE_SIZE-g)-1 -: PSUM_WIDTH] = row_valid_o ? head : '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else if (clear_i) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_i) state_nx = (num_rows_i == '0) ? DONE : DRAIN;
            DRAIN:   if (pop && last) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        row_valid_o = (state == DRAIN) && (empty == '0);
        tile_done_o = state == DONE;
        busy_o      = state != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt    <= '0;
            num_rows   <= '0;
            overflow_o <= 1'b0;
        end else if (clear_i) begin
            row_cnt    <= '0;
            num_rows   <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (state == IDLE && start_i) begin
                row_cnt  <= '0;
                num_rows <= num_rows_i;
            end else if (pop) begin
                row_cnt <= row_cnt + 1'b1;
            end
            if (|(psum_en_i & full) && !pop) overflow_o <= 1'b1;
        end
    end
endmodule
